hilo_divide_unit: RTL and testbench
===================================

# hilo_divide_unit

Multi-cycle HI/LO divide unit in the EX stage of the MIPS32 core. Executes DIV/DIVU with a 32-iteration restoring divider and owns the HI/LO registers. It serves MTHI/MTLO writes and MFHI/MFLO reads. It drives EX_ALU_Stall, which the hazard/forward unit ORs into EX_Stall, so any HI/LO access blocks while a divide is in flight.

## Interface
- WIDTH, 32, operand/HI/LO width; the iteration counter is clog2(WIDTH) bits.
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- EX_Hold  in  1  OR of every EX-stage stall source except this block (data-hazard, exception, M stall); no op is accepted while high.
- EX_Flush  in  1  EX instruction squashed; no op is accepted while high.
- Op_Div, Op_Divu, Op_Mthi, Op_Mtlo, Op_Mfhi, Op_Mflo  in  1 each  decoded EX-stage op.
- EX_Rs, EX_Rt  in  WIDTH  forwarded operands (dividend/divisor; EX_Rs is the MTHI/MTLO source).
- HI, LO  out  WIDTH  architectural HI/LO, registered; reset 0.
- Busy  out  1  divide in flight (RUN or FIX); reset 0.
- EX_ALU_Stall  out  1  Busy & (any Op_*); combinational; reset-time value 0.

## Operation
- States: IDLE, RUN, FIX. Reset → IDLE. Cnt = 0. Working registers are cleared.
- Accept condition: state IDLE & ~EX_Hold & ~EX_Flush. EX_ALU_Stall must not feed back into accept; that would create a loop through EX_Stall.
- Op priority when several are asserted: Div > Divu > Mthi > Mtlo.
- Mthi/Mtlo accepted: HI or LO ← EX_Rs at that edge. State stays IDLE.
- Div/Divu accepted: latch the operands.
  - Div: latch |EX_Rs| and |EX_Rt| as unsigned. QNeg = sign(Rs)^sign(Rt). RNeg = sign(Rs).
  - Divu: QNeg = RNeg = 0.
  - Latch DivZero = (EX_Rt == 0). Set Rem = 0, Cnt = 0, and go to RUN.
- RUN, one edge per iteration: shift {Rem, Quot} left 1. Trial = Rem − Divisor in WIDTH+1 bits. If no borrow, Rem ← Trial and the quotient LSB ← 1.
  - Cnt increments each edge; after the WIDTH-th iteration go to FIX.
- FIX, one edge:
  - LO ← QNeg ? −Quot : Quot. HI ← RNeg ? −Rem : Rem. Both use two's-complement, WIDTH-bit wrap.
  - If DivZero: HI ← original EX_Rs, LO ← all-ones, with no sign fix.
  - Then go to IDLE.
- Mfhi/Mflo: HI/LO are presented directly; the EX mux selects them. Stalled while Busy.
- EX_Flush has no effect on a divide already in RUN/FIX; it runs to completion, as MIPS requires.
- Reset mid-divide: immediate return to IDLE. HI = LO = 0 and Busy = 0. The partial result is discarded.

## Timing
- Accept edge E0 → RUN, Busy = 1.
- Iterations on edges E1..E32. FIX entered at E32.
- HI/LO written and Busy = 0 at E33. A dependent MFHI/MFLO stalls 33 cycles and reads the new value in the cycle after E33.
- A back-to-back DIV in EX during Busy stalls and is accepted at the first edge with state IDLE.
- Mthi/Mtlo latency is 1 edge. An MFHI in the next cycle sees the new value.
- Division by zero has the same 33-cycle timing as a normal divide.

## Structure
- Shared core package holds the state encoding (IDLE/RUN/FIX), WIDTH default, and the counter-width constant.
- No sub-module: the shift-subtract datapath, sign fix and FSM stay in one module.

## Test plan
- DIVU 100 / 7: Busy high for exactly 33 cycles; then LO = 14, HI = 2.
- DIV −7 / 2: LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). Also DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- DIV 5 / 0: after 33 cycles HI = 5, LO = 0xFFFFFFFF.
- MFLO presented at E1 after DIV: EX_ALU_Stall = 1 through E32; 0 after E33; LO carries the new quotient. MTHI during Busy stalls identically and writes after.
- DIV with EX_Hold = 1 for 4 cycles: no accept and Busy = 0; accepted on the first edge with EX_Hold = 0.
- Reset asserted at iteration 10: HI = LO = 0 and Busy = 0 immediately; a following DIVU 9 / 3 gives LO = 3, HI = 0.

Source files
------------

// File: rtl/hilo_divide_unit_pkg.sv
// Shared definitions for the HI/LO divide unit: FSM encoding, default width
// and the iteration-counter width helper.
package hilo_divide_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/hilo_divide_unit.sv
// EX-stage HI/LO owner: MTHI/MTLO writes, MFHI/MFLO reads and a
// multi-cycle restoring divider for DIV/DIVU.
module hilo_divide_unit
    import hilo_divide_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             EX_Hold,
    input  logic             EX_Flush,
    input  logic             Op_Div,
    input  logic             Op_Divu,
    input  logic             Op_Mthi,
    input  logic             Op_Mtlo,
    input  logic             Op_Mfhi,
    input  logic             Op_Mflo,
    input  logic [WIDTH-1:0] EX_Rs,
    input  logic [WIDTH-1:0] EX_Rt,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy,
    output logic             EX_ALU_Stall
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rs_orig;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_divzero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic [WIDTH-1:0] w_rs_abs;
    logic [WIDTH-1:0] w_rt_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;

    // Accept must not depend on EX_ALU_Stall, or the stall path would loop
    assign w_accept = (r_state == ST_IDLE) & ~EX_Hold & ~EX_Flush;

    assign w_rs_abs = (Op_Div & EX_Rs[WIDTH-1]) ? -EX_Rs : EX_Rs;
    assign w_rt_abs = (Op_Div & EX_Rt[WIDTH-1]) ? -EX_Rt : EX_Rt;

    assign w_rem_sh = {r_rem, r_quot[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_divisor};
    assign w_borrow = w_trial[WIDTH];

    assign HI           = r_hi;
    assign LO           = r_lo;
    assign Busy         = (r_state != ST_IDLE);
    assign EX_ALU_Stall = Busy & (Op_Div | Op_Divu | Op_Mthi | Op_Mtlo | Op_Mfhi | Op_Mflo);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_rs_orig <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (Op_Div | Op_Divu) begin
                            r_quot    <= w_rs_abs;
                            r_divisor <= w_rt_abs;
                            r_rs_orig <= EX_Rs;
                            r_qneg    <= Op_Div & (EX_Rs[WIDTH-1] ^ EX_Rt[WIDTH-1]);
                            r_rneg    <= Op_Div & EX_Rs[WIDTH-1];
                            r_divzero <= (EX_Rt == '0);
                            r_rem     <= '0;
                            r_cnt     <= '0;
                            r_state   <= ST_RUN;
                        end else if (Op_Mthi) begin
                            r_hi <= EX_Rs;
                        end else if (Op_Mtlo) begin
                            r_lo <= EX_Rs;
                        end
                    end
                end
                ST_RUN: begin
                    r_rem  <= w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_quot <= {r_quot[WIDTH-2:0], ~w_borrow};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Divide-by-zero leaves the raw dividend in HI, unsigned-fixed
                    if (r_divzero) begin
                        r_hi <= r_rs_orig;
                        r_lo <= '1;
                    end else begin
                        r_hi <= r_rneg ? -r_rem  : r_rem;
                        r_lo <= r_qneg ? -r_quot : r_quot;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divide_unit.sv
// Scoreboard bench for hilo_divide_unit: expected HI/LO pushed at divide
// issue, popped and compared when Busy drops.
module tb_hilo_divide_unit;

    logic        clock;
    logic        reset;
    logic        EX_Hold;
    logic        EX_Flush;
    logic        Op_Div;
    logic        Op_Divu;
    logic        Op_Mthi;
    logic        Op_Mtlo;
    logic        Op_Mfhi;
    logic        Op_Mflo;
    logic [31:0] EX_Rs;
    logic [31:0] EX_Rt;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        EX_ALU_Stall;

    int          checks;
    int          errors;
    logic [31:0] q_hi[$];
    logic [31:0] q_lo[$];

    hilo_divide_unit #(.WIDTH(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .EX_Hold      (EX_Hold),
        .EX_Flush     (EX_Flush),
        .Op_Div       (Op_Div),
        .Op_Divu      (Op_Divu),
        .Op_Mthi      (Op_Mthi),
        .Op_Mtlo      (Op_Mtlo),
        .Op_Mfhi      (Op_Mfhi),
        .Op_Mflo      (Op_Mflo),
        .EX_Rs        (EX_Rs),
        .EX_Rt        (EX_Rt),
        .HI           (HI),
        .LO           (LO),
        .Busy         (Busy),
        .EX_ALU_Stall (EX_ALU_Stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Reference: MIPS DIV/DIVU semantics including the fixed div-by-zero result
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (!sgn) begin
            lo = a / b;
            hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
        end else begin
            lo = sa / sb;
            hi = sa % sb;
        end
    endtask

    task automatic push_exp(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] h;
        logic [31:0] l;
        model(sgn, a, b, h, l);
        q_hi.push_back(h);
        q_lo.push_back(l);
    endtask

    task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        Op_Div  = sgn;
        Op_Divu = ~sgn;
        EX_Rs   = a;
        EX_Rt   = b;
        push_exp(sgn, a, b);
        @(posedge clock);
        #1;
        Op_Div  = 1'b0;
        Op_Divu = 1'b0;
    endtask

    // Count Busy and stall cycles (bounded), then pop and compare the result
    task automatic finish_div(input string tag, input int want_stall);
        int n;
        int ns;
        n  = 0;
        ns = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (!Busy) break;
            n++;
            if (EX_ALU_Stall) ns++;
        end
        check_eq({tag, "_busy_cycles"}, n, 33);
        check_eq({tag, "_stall_cycles"}, ns, want_stall);
        if (q_hi.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            check_eq({tag, "_hi"}, HI, q_hi.pop_front());
            check_eq({tag, "_lo"}, LO, q_lo.pop_front());
        end
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start_div(sgn, a, b);
        finish_div(tag, 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        EX_Hold  = 1'b0;
        EX_Flush = 1'b0;
        Op_Div   = 1'b0;
        Op_Divu  = 1'b0;
        Op_Mthi  = 1'b0;
        Op_Mtlo  = 1'b0;
        Op_Mfhi  = 1'b0;
        Op_Mflo  = 1'b0;
        EX_Rs    = '0;
        EX_Rt    = '0;
        repeat (3) @(posedge clock);
        #1;
        Op_Mfhi = 1'b1;
        #1;
        check_eq("rst_hi", HI, 32'd0);
        check_eq("rst_lo", LO, 32'd0);
        check_eq("rst_busy", {31'd0, Busy}, 32'd0);
        check_eq("rst_stall", {31'd0, EX_ALU_Stall}, 32'd0);
        Op_Mfhi = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // MTHI / MTLO, one-edge latency and Mthi-over-Mtlo priority
        @(negedge clock);
        Op_Mthi = 1'b1; EX_Rs = 32'hAAAA_5555;
        @(negedge clock);
        Op_Mthi = 1'b0;
        check_eq("mthi", HI, 32'hAAAA_5555);
        Op_Mtlo = 1'b1; EX_Rs = 32'h1357_9BDF;
        @(negedge clock);
        Op_Mtlo = 1'b0;
        check_eq("mtlo", LO, 32'h1357_9BDF);
        Op_Mthi = 1'b1; Op_Mtlo = 1'b1; EX_Rs = 32'h0BAD_F00D;
        @(negedge clock);
        Op_Mthi = 1'b0; Op_Mtlo = 1'b0;
        check_eq("prio_hi", HI, 32'h0BAD_F00D);
        check_eq("prio_lo", LO, 32'h1357_9BDF);

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        check_eq("divu_100_7_lo_const", LO, 32'd14);
        check_eq("divu_100_7_hi_const", HI, 32'd2);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        check_eq("div_m7_2_lo_const", LO, 32'hFFFF_FFFD);
        check_eq("div_m7_2_hi_const", HI, 32'hFFFF_FFFF);
        do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check_eq("div_min_m1_lo_const", LO, 32'h8000_0000);
        do_div("div_5_0", 1'b1, 32'd5, 32'd0);
        check_eq("div_5_0_hi_const", HI, 32'd5);
        check_eq("div_5_0_lo_const", LO, 32'hFFFF_FFFF);
        do_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
        do_div("divu_big_3", 1'b0, 32'hFFFF_FFFF, 32'd3);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);

        // Dependent MFLO held from E1: stalls for the whole divide
        start_div(1'b1, 32'd1000, 32'd33);
        Op_Mflo = 1'b1;
        finish_div("mflo_dep", 33);
        check_eq("mflo_stall_after", {31'd0, EX_ALU_Stall}, 32'd0);
        Op_Mflo = 1'b0;

        // MTHI during Busy stalls and lands on the first idle edge
        start_div(1'b0, 32'd77, 32'd5);
        Op_Mthi = 1'b1;
        EX_Rs   = 32'h0000_1234;
        finish_div("mthi_dep", 33);
        @(negedge clock);
        Op_Mthi = 1'b0;
        check_eq("mthi_after_div", HI, 32'h0000_1234);

        // EX_Hold and EX_Flush block acceptance
        @(negedge clock);
        EX_Hold = 1'b1; Op_Div = 1'b1; EX_Rs = 32'd50; EX_Rt = 32'd6;
        push_exp(1'b1, 32'd50, 32'd6);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            check_eq("hold_no_accept", {31'd0, Busy}, 32'd0);
        end
        @(negedge clock);
        EX_Hold = 1'b0;
        @(posedge clock);
        #1;
        Op_Div = 1'b0;
        check_eq("hold_release_busy", {31'd0, Busy}, 32'd1);
        finish_div("hold_div", 0);

        @(negedge clock);
        EX_Flush = 1'b1; Op_Divu = 1'b1; EX_Rs = 32'd9; EX_Rt = 32'd2;
        @(posedge clock);
        #1;
        check_eq("flush_no_accept", {31'd0, Busy}, 32'd0);
        EX_Flush = 1'b0;
        push_exp(1'b0, 32'd9, 32'd2);
        @(posedge clock);
        #1;
        Op_Divu  = 1'b0;
        EX_Flush = 1'b1;
        finish_div("flush_in_run", 0);
        EX_Flush = 1'b0;

        // Reset at iteration 10 discards the divide
        start_div(1'b1, 32'd123456, 32'd789);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_eq("midrst_hi", HI, 32'd0);
        check_eq("midrst_lo", LO, 32'd0);
        check_eq("midrst_busy", {31'd0, Busy}, 32'd0);
        void'(q_hi.pop_front());
        void'(q_lo.pop_front());
        @(negedge clock);
        reset = 1'b0;
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3);
        check_eq("divu_9_3_lo_const", LO, 32'd3);
        check_eq("divu_9_3_hi_const", HI, 32'd0);

        for (int k = 0; k < 6; k++) begin
            logic        sgn;
            logic [31:0] a;
            logic [31:0] b;
            sgn = k[0];
            a   = $urandom();
            b   = (k == 5) ? 32'd0 : ($urandom() >> $urandom_range(0, 28));
            do_div($sformatf("rand%0d", k), sgn, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
